// File: rtl/seq_onehot_decoder_pkg.sv
// Shared types and constants for the sequenced one-hot decoder.
// Output polarity is selected by the SEQ_DEC_ACTIVE_LOW_EN macro.
package seq_dec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SCAN
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int MAX_OUT_W = 64;

  function automatic int out_w(input int sel_w);
    return 1 << sel_w;
  endfunction

  // XOR-ing a decoded line with this pattern yields the driven polarity.
`ifdef SEQ_DEC_ACTIVE_LOW_EN
  localparam logic [MAX_OUT_W-1:0] Y_INACTIVE = '1;
`else
  localparam logic [MAX_OUT_W-1:0] Y_INACTIVE = '0;
`endif

endpackage

// File: rtl/seq_onehot_decoder_onehot_dec.sv
// Combinational binary-to-one-hot map, always active-high.
module onehot_dec #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      code,
  output logic [2**SEL_W-1:0]   onehot
);

  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/seq_onehot_decoder.sv
// Registered N-to-2^N one-hot decoder with DIRECT hold and SCAN walk modes.
// Define SEQ_DEC_ACTIVE_LOW_EN for active-low y (inactive value all ones).
module seq_onehot_decoder
  import seq_dec_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_mode,
  input  logic [DWELL_W-1:0]        in_dwell,
  output logic [out_w(SEL_W)-1:0]   y,
  output logic                      y_valid,
  output logic                      busy,
  output logic                      scan_done
);

  localparam int OUT_W = out_w(SEL_W);
  localparam logic [OUT_W-1:0] Y_OFF = Y_INACTIVE[OUT_W-1:0];

  state_t             state, next_state;
  logic [SEL_W-1:0]   code, next_code;
  logic [DWELL_W-1:0] dwell_cnt, next_dwell;
  logic [DWELL_W-1:0] dwell_reload, next_reload;
  logic               next_scan_done;
  logic               next_y_valid;
  logic [OUT_W-1:0]   next_y;
  logic [OUT_W-1:0]   decoded;
  logic               accept;

  assign accept = in_valid && in_ready;

  // Decoding the upcoming code lets y be registered in the same cycle the code changes.
  onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .code   (next_code),
    .onehot (decoded)
  );

  always_comb begin
    next_state     = state;
    next_code      = code;
    next_dwell     = dwell_cnt;
    next_reload    = dwell_reload;
    next_scan_done = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          next_code = in_sel;
          if (in_mode == MODE_SCAN) begin
            next_state  = SCAN;
            next_dwell  = in_dwell;
            next_reload = in_dwell;
          end else begin
            next_state = HOLD;
          end
        end
      end
      SCAN: begin
        if (dwell_cnt != '0) begin
          next_dwell = dwell_cnt - DWELL_W'(1);
        end else if (&code) begin
          next_state     = IDLE;
          next_scan_done = 1'b1;
        end else begin
          next_code  = code + SEL_W'(1);
          next_dwell = dwell_reload;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    next_y_valid = (next_state != IDLE);
    next_y       = next_y_valid ? (decoded ^ Y_OFF) : Y_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      code         <= '0;
      dwell_cnt    <= '0;
      dwell_reload <= '0;
      y            <= Y_OFF;
      y_valid      <= 1'b0;
      busy         <= 1'b0;
      scan_done    <= 1'b0;
      in_ready     <= 1'b1;
    end else begin
      state        <= next_state;
      code         <= next_code;
      dwell_cnt    <= next_dwell;
      dwell_reload <= next_reload;
      y            <= next_y;
      y_valid      <= next_y_valid;
      busy         <= (next_state == SCAN);
      scan_done    <= next_scan_done;
      in_ready     <= (next_state != SCAN);
    end
  end

endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Self-checking bench: directed scenarios then random traffic against a queue-based model.
module tb_seq_onehot_decoder;

  localparam int SEL_W   = 2;
  localparam int DWELL_W = 4;
  localparam int OUT_W   = 1 << SEL_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel;
  logic               in_mode;
  logic [DWELL_W-1:0] in_dwell;
  logic [OUT_W-1:0]   y;
  logic               y_valid;
  logic               busy;
  logic               scan_done;

  int n_cmp = 0;
  int n_err = 0;

  // Model: queue of codes still to be shown in SCAN (one entry per cycle), or a held code.
  int scan_q[$];
  int hold_code = -1;
  bit exp_done  = 1'b0;

  seq_onehot_decoder #(
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_mode   (in_mode),
    .in_dwell  (in_dwell),
    .y         (y),
    .y_valid   (y_valid),
    .busy      (busy),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge(input bit v, input int sel, input bit mode, input int dwell,
                           input bit r);
    exp_done = 1'b0;
    if (r) begin
      scan_q.delete();
      hold_code = -1;
    end else if (scan_q.size() > 0) begin
      void'(scan_q.pop_front());
      if (scan_q.size() == 0) exp_done = 1'b1;
    end else if (v) begin
      if (mode) begin
        hold_code = -1;
        for (int c = sel; c < OUT_W; c++)
          for (int k = 0; k <= dwell; k++) scan_q.push_back(c);
      end else begin
        hold_code = sel;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [OUT_W-1:0] ey;
    logic             ev;
    if (scan_q.size() > 0) begin
      ey = OUT_W'(1) << scan_q[0];
      ev = 1'b1;
    end else if (hold_code >= 0) begin
      ey = OUT_W'(1) << hold_code;
      ev = 1'b1;
    end else begin
      ey = '0;
      ev = 1'b0;
    end
`ifdef SEQ_DEC_ACTIVE_LOW_EN
    ey = ~ey;
`endif
    check1({tag, ".y"}, 64'(y), 64'(ey));
    check1({tag, ".y_valid"}, 64'(y_valid), 64'(ev));
    check1({tag, ".busy"}, 64'(busy), 64'(scan_q.size() > 0));
    check1({tag, ".in_ready"}, 64'(in_ready), 64'(scan_q.size() == 0));
    check1({tag, ".scan_done"}, 64'(scan_done), 64'(exp_done));
  endtask

  task automatic applyStimulus(input string tag, input bit v, input int sel, input bit mode,
                               input int dwell, input bit r);
    rst      = r;
    in_valid = v;
    in_sel   = SEL_W'(sel);
    in_mode  = mode;
    in_dwell = DWELL_W'(dwell);
    @(posedge clk);
    modelEdge(v, sel, mode, dwell, r);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    // Reset sequence
    for (int i = 0; i < 3; i++) applyStimulus("reset", 1'b0, 0, 1'b0, 0, 1'b1);

    // DIRECT back-to-back, then hold
    applyStimulus("direct_a", 1'b1, 2, 1'b0, 0, 1'b0);
    applyStimulus("direct_b", 1'b1, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("direct_hold", 1'b0, 3, 1'b1, 5, 1'b0);

    // SCAN full sweep
    applyStimulus("scan_start", 1'b1, 0, 1'b1, 2, 1'b0);
    for (int i = 0; i < 14; i++) applyStimulus("scan_sweep", 1'b0, 1, 1'b0, 7, 1'b0);

    // SCAN from top code, request held pending across the scan
    applyStimulus("edge_start", 1'b1, 3, 1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("edge_pend", 1'b1, 1, 1'b0, 0, 1'b0);

    // Mid-activity reset during a scan
    applyStimulus("abort_start", 1'b1, 0, 1'b1, 1, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus("abort_run", 1'b0, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("abort_rst", 1'b1, 2, 1'b1, 0, 1'b1);
    applyStimulus("abort_direct", 1'b1, 1, 1'b0, 0, 1'b0);
    applyStimulus("abort_hold", 1'b0, 0, 1'b0, 0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus("random",
                    ($urandom_range(0, 9) < 4),
                    int'($urandom_range(0, OUT_W - 1)),
                    1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)),
                    ($urandom_range(0, 59) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
